// File: rtl/axi4_stream_dest_router.sv
// 1-to-2 AXI4-Stream packet router: the TUSER destination bit on a packet's first beat steers the whole packet to m0 or m1.
// One-cycle registered latency per port; input stalls only on the selected port being full and not draining (head-of-line).
module axi4_stream_dest_router #(
  parameter int TDATA_L  = 512,
  parameter int TUSER_L  = 81,
  parameter int TKEEP_L  = 16,
  parameter int DEST_BIT = 80
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TDATA_L-1:0] axi_s_tdata_i,
  input  logic [TUSER_L-1:0] axi_s_tuser_i,
  input  logic               axi_s_tlast_i,
  input  logic [TKEEP_L-1:0] axi_s_tkeep_i,
  input  logic               axi_s_tvalid_i,
  output logic               axi_s_tready_o,
  output logic [TDATA_L-1:0] axi_m0_tdata_o,
  output logic [TUSER_L-1:0] axi_m0_tuser_o,
  output logic               axi_m0_tlast_o,
  output logic [TKEEP_L-1:0] axi_m0_tkeep_o,
  output logic               axi_m0_tvalid_o,
  input  logic               axi_m0_tready_i,
  output logic [TDATA_L-1:0] axi_m1_tdata_o,
  output logic [TUSER_L-1:0] axi_m1_tuser_o,
  output logic               axi_m1_tlast_o,
  output logic [TKEEP_L-1:0] axi_m1_tkeep_o,
  output logic               axi_m1_tvalid_o,
  input  logic               axi_m1_tready_i,
  output logic               in_pkt_o,
  output logic               dest_o
);

  typedef struct packed {
    logic [TDATA_L-1:0] tdata;
    logic [TUSER_L-1:0] tuser;
    logic [TKEEP_L-1:0] tkeep;
    logic               tlast;
  } beat_t;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       dest_q, dest_d;
  logic [1:0] vld_q, vld_d;
  beat_t      m0_beat_q, m0_beat_d;
  beat_t      m1_beat_q, m1_beat_d;

  beat_t      s_beat;
  logic       sel;
  logic       s_rdy;
  logic       accept;
  logic [1:0] m_rdy;
  logic [1:0] load;

  assign s_beat = {axi_s_tdata_i, axi_s_tuser_i, axi_s_tkeep_i, axi_s_tlast_i};
  assign m_rdy  = {axi_m1_tready_i, axi_m0_tready_i};

  // State register: only control flops are reset; payload registers are qualified by valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dest_q  <= 1'b0;
      vld_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    m0_beat_q <= m0_beat_d;
    m1_beat_q <= m1_beat_d;
  end

  // Next-state logic: a single-beat packet never enters LOCKED.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    case (state_q)
      IDLE: begin
        if (accept && !axi_s_tlast_i) begin
          state_d = LOCKED;
          dest_d  = sel;
        end
      end
      LOCKED: begin
        if (accept && axi_s_tlast_i) state_d = IDLE;
      end
    endcase
  end

  // Output/datapath logic: ready looks only at the selected port.
  always_comb begin
    sel       = (state_q == LOCKED) ? dest_q : axi_s_tuser_i[DEST_BIT];
    s_rdy     = ~vld_q[sel] | m_rdy[sel];
    accept    = axi_s_tvalid_i & s_rdy;
    load      = 2'b00;
    load[sel] = accept;
    vld_d     = (vld_q & ~m_rdy) | load;
    m0_beat_d = load[0] ? s_beat : m0_beat_q;
    m1_beat_d = load[1] ? s_beat : m1_beat_q;
  end

  assign axi_s_tready_o  = s_rdy;

  assign axi_m0_tdata_o  = m0_beat_q.tdata;
  assign axi_m0_tuser_o  = m0_beat_q.tuser;
  assign axi_m0_tkeep_o  = m0_beat_q.tkeep;
  assign axi_m0_tlast_o  = m0_beat_q.tlast;
  assign axi_m0_tvalid_o = vld_q[0];

  assign axi_m1_tdata_o  = m1_beat_q.tdata;
  assign axi_m1_tuser_o  = m1_beat_q.tuser;
  assign axi_m1_tkeep_o  = m1_beat_q.tkeep;
  assign axi_m1_tlast_o  = m1_beat_q.tlast;
  assign axi_m1_tvalid_o = vld_q[1];

  assign in_pkt_o = (state_q == LOCKED);
  assign dest_o   = dest_q;

endmodule

// File: tb/tb_axi4_stream_dest_router.sv
// Directed bench for axi4_stream_dest_router: per-cycle vector table plus a hand-written stall/drain sequence.
module tb_axi4_stream_dest_router;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  tag = 32'h0;
  logic [511:0] s_tdata;
  logic [80:0]  s_tuser;
  logic [15:0]  s_tkeep;
  logic         s_tlast = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [511:0] m0_tdata, m1_tdata;
  logic [80:0]  m0_tuser, m1_tuser;
  logic [15:0]  m0_tkeep, m1_tkeep;
  logic         m0_tlast, m1_tlast, m0_tvalid, m1_tvalid;
  logic         m0_tready = 1'b1;
  logic         m1_tready = 1'b1;
  logic         in_pkt, dest;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // The destination bit of each beat is the top bit of its tag.
  function automatic logic [80:0] usr(input logic [31:0] t);
    return {t[31], 48'h0, t};
  endfunction

  assign s_tdata = {16{tag}};
  assign s_tuser = usr(tag);
  assign s_tkeep = tag[15:0];

  axi4_stream_dest_router dut (
    .clk(clk), .rst(rst),
    .axi_s_tdata_i(s_tdata), .axi_s_tuser_i(s_tuser), .axi_s_tlast_i(s_tlast),
    .axi_s_tkeep_i(s_tkeep), .axi_s_tvalid_i(s_tvalid), .axi_s_tready_o(s_tready),
    .axi_m0_tdata_o(m0_tdata), .axi_m0_tuser_o(m0_tuser), .axi_m0_tlast_o(m0_tlast),
    .axi_m0_tkeep_o(m0_tkeep), .axi_m0_tvalid_o(m0_tvalid), .axi_m0_tready_i(m0_tready),
    .axi_m1_tdata_o(m1_tdata), .axi_m1_tuser_o(m1_tuser), .axi_m1_tlast_o(m1_tlast),
    .axi_m1_tkeep_o(m1_tkeep), .axi_m1_tvalid_o(m1_tvalid), .axi_m1_tready_i(m1_tready),
    .in_pkt_o(in_pkt), .dest_o(dest)
  );

  typedef struct {
    logic        rst, vld, last, r0, r1;
    logic [31:0] tag;
    logic        e_rdy;
    logic        e0v;
    logic [31:0] e0t;
    logic        e0l;
    logic        e1v;
    logic [31:0] e1t;
    logic        e1l;
    logic        e_pkt, e_dest;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, v, l, r0, r1, input logic [31:0] t, input logic rdy,
                              input logic e0v, input logic [31:0] e0t, input logic e0l,
                              input logic e1v, input logic [31:0] e1t, input logic e1l,
                              input logic pkt, dst);
    vec_t x;
    x.rst = r; x.vld = v; x.last = l; x.r0 = r0; x.r1 = r1; x.tag = t; x.e_rdy = rdy;
    x.e0v = e0v; x.e0t = e0t; x.e0l = e0l; x.e1v = e1v; x.e1t = e1t; x.e1l = e1l;
    x.e_pkt = pkt; x.e_dest = dst;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_port(input string nm, input logic v, input logic [511:0] d, input logic [80:0] u,
                          input logic [15:0] k, input logic l,
                          input logic ev, input logic [31:0] et, input logic el);
    chk({nm, "_vld"}, 512'(v), 512'(ev));
    if (ev) begin
      chk({nm, "_dat"}, d, {16{et}});
      chk({nm, "_usr"}, 512'(u), 512'(usr(et)));
      chk({nm, "_keep"}, 512'(k), 512'(et[15:0]));
      chk({nm, "_last"}, 512'(l), 512'(el));
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [31:0] t, input logic r0, input logic r1);
    s_tvalid = v; s_tlast = l; tag = t; m0_tready = r0; m1_tready = r1;
  endtask

  initial begin
    int n;
    bit done;
    // rst vld last r0 r1 tag | rdy | m0 v/tag/last | m1 v/tag/last | in_pkt dest
    tbl[0]  = mk(1,0,0,1,1,32'h0,        0, 0,32'h0,0,        0,32'h0,0,        0,0);
    tbl[1]  = mk(0,1,1,1,1,32'h0A001000, 1, 1,32'h0A001000,1, 0,32'h0,0,        0,0);
    tbl[2]  = mk(0,0,0,1,1,32'h0,        1, 0,32'h0,0,        0,32'h0,0,        0,0);
    tbl[3]  = mk(0,1,0,1,1,32'h81000001, 1, 0,32'h0,0,        1,32'h81000001,0, 1,1);
    tbl[4]  = mk(0,1,0,1,1,32'h01000002, 1, 0,32'h0,0,        1,32'h01000002,0, 1,1);
    tbl[5]  = mk(0,1,1,1,1,32'h01000003, 1, 0,32'h0,0,        1,32'h01000003,1, 0,0);
    tbl[6]  = mk(0,0,0,1,1,32'h0,        1, 0,32'h0,0,        0,32'h0,0,        0,0);
    tbl[7]  = mk(0,1,1,1,1,32'h02000001, 1, 1,32'h02000001,1, 0,32'h0,0,        0,0);
    tbl[8]  = mk(0,1,1,1,1,32'h82000002, 1, 0,32'h0,0,        1,32'h82000002,1, 0,0);
    tbl[9]  = mk(0,1,1,1,1,32'h02000003, 1, 1,32'h02000003,1, 0,32'h0,0,        0,0);
    tbl[10] = mk(0,1,1,1,1,32'h82000004, 1, 0,32'h0,0,        1,32'h82000004,1, 0,0);
    tbl[11] = mk(0,0,0,1,1,32'h0,        1, 0,32'h0,0,        0,32'h0,0,        0,0);
    tbl[12] = mk(0,1,0,1,0,32'h83000001, 1, 0,32'h0,0,        1,32'h83000001,0, 1,1);
    tbl[13] = mk(0,1,1,1,0,32'h03000002, 0, 0,32'h0,0,        1,32'h83000001,0, 1,1);
    tbl[14] = mk(0,1,1,1,0,32'h03000002, 0, 0,32'h0,0,        1,32'h83000001,0, 1,1);
    tbl[15] = mk(0,1,1,1,1,32'h03000002, 1, 0,32'h0,0,        1,32'h03000002,1, 0,0);
    tbl[16] = mk(0,0,0,1,1,32'h0,        1, 0,32'h0,0,        0,32'h0,0,        0,0);
    tbl[17] = mk(0,1,0,1,1,32'h04000001, 1, 1,32'h04000001,0, 0,32'h0,0,        1,0);
    tbl[18] = mk(0,0,0,1,1,32'h0,        1, 0,32'h0,0,        0,32'h0,0,        1,0);
    tbl[19] = mk(0,0,0,1,1,32'h0,        1, 0,32'h0,0,        0,32'h0,0,        1,0);
    tbl[20] = mk(0,1,0,1,1,32'h84000002, 1, 1,32'h84000002,0, 0,32'h0,0,        1,0);
    tbl[21] = mk(0,0,0,1,1,32'h0,        1, 0,32'h0,0,        0,32'h0,0,        1,0);
    tbl[22] = mk(0,1,1,1,1,32'h04000003, 1, 1,32'h04000003,1, 0,32'h0,0,        0,0);
    tbl[23] = mk(0,1,1,1,1,32'h85000001, 1, 0,32'h0,0,        1,32'h85000001,1, 0,0);
    tbl[24] = mk(0,0,0,1,1,32'h0,        1, 0,32'h0,0,        0,32'h0,0,        0,0);
    tbl[25] = mk(0,1,0,1,1,32'h06000001, 1, 1,32'h06000001,0, 0,32'h0,0,        1,0);
    tbl[26] = mk(0,1,0,1,1,32'h06000002, 1, 1,32'h06000002,0, 0,32'h0,0,        1,0);
    tbl[27] = mk(1,0,0,1,1,32'h0,        0, 0,32'h0,0,        0,32'h0,0,        0,0);
    tbl[28] = mk(0,1,1,1,1,32'h87000001, 1, 0,32'h0,0,        1,32'h87000001,1, 0,0);
    tbl[29] = mk(0,0,0,1,1,32'h0,        1, 0,32'h0,0,        0,32'h0,0,        0,0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      drive(tbl[i].vld, tbl[i].last, tbl[i].tag, tbl[i].r0, tbl[i].r1);
      #1;
      if (!tbl[i].rst) chk($sformatf("v%0d_rdy", i), 512'(s_tready), 512'(tbl[i].e_rdy));
      @(posedge clk);
      #1;
      chk_port($sformatf("v%0d_m0", i), m0_tvalid, m0_tdata, m0_tuser, m0_tkeep, m0_tlast,
               tbl[i].e0v, tbl[i].e0t, tbl[i].e0l);
      chk_port($sformatf("v%0d_m1", i), m1_tvalid, m1_tdata, m1_tuser, m1_tkeep, m1_tlast,
               tbl[i].e1v, tbl[i].e1t, tbl[i].e1l);
      chk($sformatf("v%0d_pkt", i), 512'(in_pkt), 512'(tbl[i].e_pkt));
      if (tbl[i].e_pkt || tbl[i].rst) chk($sformatf("v%0d_dest", i), 512'(dest), 512'(tbl[i].e_dest));
    end

    // Stalled m0 holds its beat stable for a random number of cycles, then drains and reloads.
    @(negedge clk);
    drive(1, 1, 32'h08000001, 0, 1);
    @(posedge clk);
    #1;
    chk_port("hol_k1", m0_tvalid, m0_tdata, m0_tuser, m0_tkeep, m0_tlast, 1, 32'h08000001, 1);
    @(negedge clk);
    drive(1, 1, 32'h08000002, 0, 1);
    n = $urandom_range(2, 5);
    for (int c = 0; c < n; c++) begin
      #1;
      chk($sformatf("hol_rdy%0d", c), 512'(s_tready), 512'(0));
      @(posedge clk);
      #1;
      chk_port($sformatf("hol_hold%0d", c), m0_tvalid, m0_tdata, m0_tuser, m0_tkeep, m0_tlast,
               1, 32'h08000001, 1);
      chk($sformatf("hol_m1v%0d", c), 512'(m1_tvalid), 512'(0));
      @(negedge clk);
    end
    drive(1, 1, 32'h08000002, 1, 1);
    #1;
    chk("hol_rel_rdy", 512'(s_tready), 512'(1));
    @(posedge clk);
    #1;
    chk_port("hol_k2", m0_tvalid, m0_tdata, m0_tuser, m0_tkeep, m0_tlast, 1, 32'h08000002, 1);
    @(negedge clk);
    drive(0, 0, 32'h0, 1, 1);
    done = 1'b0;
    for (int c = 0; c < 5 && !done; c++) begin
      @(posedge clk);
      #1;
      if (!m0_tvalid) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL drain_timeout: m0 valid still %0d after 5 cycles, required 0", m0_tvalid);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
